// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side arbiter.
//   - rd_state_e : arbiter FSM states
//   - *_DEF      : default parameter values
//   - len_decode : burst-length field to word count (0 means 2^len_w)
package fifo_rd_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned LEN_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // A zero length field encodes the largest burst the field can name.
  function automatic int unsigned len_decode(input int unsigned len, input int unsigned len_w);
    return (len == 0) ? (32'd1 << len_w) : len;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_picker.sv
// Combinational round-robin priority selector.
// Searches req from bit ptr upward with wrap and returns the first set bit.
//   req        : request vector
//   ptr        : search start index
//   pick_oh_c  : one-hot winner (zero when no request)
//   pick_idx_c : winner index
//   any_c      : at least one request present
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick_oh_c,
  output logic [IDX_W-1:0] pick_idx_c,
  output logic             any_c
);

  // First set bit at or after ptr, wrapping modulo N.
  always_comb begin
    logic [IDX_W-1:0] j;
    pick_oh_c  = '0;
    pick_idx_c = '0;
    any_c      = 1'b0;
    j          = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IDX_W'((32'(ptr) + k) % N);
      if (!any_c && req[j]) begin
        any_c         = 1'b1;
        pick_oh_c[j]  = 1'b1;
        pick_idx_c    = j;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin scheduler sharing the async FIFO read port between NUM_REQ
// consumers. One consumer owns the port per burst; the arbiter pops on its
// behalf into a one-entry output register with per-consumer valid/ready.
//   rclk, Rrst_n      : read clock, async active-low reset
//   rdata, rempty     : FIFO head word and empty flag
//   rinc              : pop strobe (combinational)
//   req, req_len      : per-requester burst request and length (0 = 2^LEN_W)
//   rd_ready          : per-consumer accept
//   grant             : one-hot port owner
//   rd_data, rd_valid : output word and one-hot valid to the owner
//   burst_done        : one-cycle pulse on burst completion or abort
//   busy              : arbiter not idle
module fifo_read_arbiter
  import fifo_rd_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input  logic                     rclk,
  input  logic                     Rrst_n,
  input  logic [DATA_W-1:0]        rdata,
  input  logic                     rempty,
  output logic                     rinc,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ-1:0]       rd_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic [DATA_W-1:0]        rd_data,
  output logic [NUM_REQ-1:0]       rd_valid,
  output logic [NUM_REQ-1:0]       burst_done,
  output logic                     busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned REM_W = LEN_W + 1;

  rd_state_e          state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt, burst_done_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [REM_W-1:0]   remaining, remaining_nxt;
  logic               out_full, out_full_nxt;
  logic [DATA_W-1:0]  rd_data_nxt;
  logic               busy_nxt;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [LEN_W-1:0]   pick_len;
  logic               owner_req;
  logic               owner_ready;
  logic               accept;
  logic               pop;
  logic               finish;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req),
    .ptr        (rr_ptr),
    .pick_oh_c  (pick_oh),
    .pick_idx_c (pick_idx),
    .any_c      (pick_any)
  );

  assign pick_len    = LEN_W'(req_len >> (32'(pick_idx) * LEN_W));
  assign owner_req   = req[gidx];
  assign owner_ready = rd_ready[gidx];
  assign accept      = out_full & owner_ready;

  // Pop only when the owner can absorb the word this cycle or the next.
  assign pop  = (state == XFER) & ~rempty & (remaining != '0) & owner_req &
                (~out_full | owner_ready);
  assign rinc = pop;

  assign rd_valid = {NUM_REQ{out_full}} & grant;

  // State register
  always_ff @(posedge rclk or negedge Rrst_n) begin
    if (!Rrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and datapath next values
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    gidx_nxt       = gidx;
    rr_ptr_nxt     = rr_ptr;
    remaining_nxt  = remaining;
    out_full_nxt   = out_full;
    rd_data_nxt    = rd_data;
    burst_done_nxt = '0;
    finish         = 1'b0;

    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt     = pick_oh;
          gidx_nxt      = pick_idx;
          remaining_nxt = REM_W'(len_decode(32'(pick_len), LEN_W));
          state_nxt     = XFER;
        end
      end
      XFER: begin
        if (!owner_req) begin
          finish = 1'b1;
        end else if (pop) begin
          rd_data_nxt   = rdata;
          out_full_nxt  = 1'b1;
          remaining_nxt = remaining - REM_W'(1);
          if (remaining == REM_W'(1)) state_nxt = DRAIN;
        end else if (accept) begin
          out_full_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (!owner_req || accept) finish = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Completion and abort share one exit path; an aborted held word is dropped.
    if (finish) begin
      out_full_nxt           = 1'b0;
      grant_nxt              = '0;
      burst_done_nxt[gidx]   = 1'b1;
      remaining_nxt          = '0;
      rr_ptr_nxt             = IDX_W'((32'(gidx) + 32'd1) % NUM_REQ);
      state_nxt              = IDLE;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge rclk or negedge Rrst_n) begin
    if (!Rrst_n) begin
      grant      <= '0;
      gidx       <= '0;
      rr_ptr     <= '0;
      remaining  <= '0;
      out_full   <= 1'b0;
      rd_data    <= '0;
      burst_done <= '0;
      busy       <= 1'b0;
    end else begin
      grant      <= grant_nxt;
      gidx       <= gidx_nxt;
      rr_ptr     <= rr_ptr_nxt;
      remaining  <= remaining_nxt;
      out_full   <= out_full_nxt;
      rd_data    <= rd_data_nxt;
      burst_done <= burst_done_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter: FIFO model, transaction-level
// arbitration/data scoreboard, directed scenarios and a randomized phase.
module tb_fifo_read_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 4;

  logic            rclk = 1'b0;
  logic            Rrst_n;
  logic [DW-1:0]   rdata;
  logic            rempty;
  logic            rinc;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    rd_ready;
  logic [N-1:0]    grant;
  logic [DW-1:0]   rd_data;
  logic [N-1:0]    rd_valid;
  logic [N-1:0]    burst_done;
  logic            busy;

  fifo_read_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LEN_W(LW)) dut (
    .rclk       (rclk),
    .Rrst_n     (Rrst_n),
    .rdata      (rdata),
    .rempty     (rempty),
    .rinc       (rinc),
    .req        (req),
    .req_len    (req_len),
    .rd_ready   (rd_ready),
    .grant      (grant),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .burst_done (burst_done),
    .busy       (busy)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // FIFO contents (fq) and words still owed to consumers in order (eq).
  logic [DW-1:0] fq[$];
  logic [DW-1:0] eq[$];
  logic [DW-1:0] wcnt = 16'h1000;

  function automatic void drive_fifo();
    rempty = (fq.size() == 0);
    rdata  = rempty ? '0 : fq[0];
  endfunction

  task automatic push(input int n);
    for (int k = 0; k < n; k++) begin
      fq.push_back(wcnt);
      eq.push_back(wcnt);
      wcnt = wcnt + 16'd1;
    end
    drive_fifo();
  endtask

  task automatic flush();
    fq.delete();
    eq.delete();
    drive_fifo();
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*LW +: LW] = LW'(v);
  endtask

  // Transaction-level reference: who owns the port and how many words it is owed.
  int           owner = -1;
  int           mptr  = 0;
  int           mlen  = 0;
  int           mgot  = 0;
  logic         model_en = 1'b0;
  logic [N-1:0] c_hs, c_idle, prev_grant;
  logic [DW-1:0] c_data;
  logic [N*LW-1:0] c_len;
  logic         c_pop;
  int           pop_cnt = 0;
  int           gq[$];

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int blen(input logic [N*LW-1:0] lv, input int i);
    logic [LW-1:0] f;
    f = lv[i*LW +: LW];
    return (f == 0) ? (1 << LW) : int'(f);
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_check();
    logic [N-1:0] exp_done;
    int w;
    exp_done = '0;
    if (owner >= 0) begin
      chk("valid_to_owner", 32'(c_hs & ~oh(owner)), 0);
      if (c_hs[owner]) begin
        if (eq.size() == 0) chk("data_unexpected", 1, 0);
        else begin
          chk("rd_data", 32'(c_data), 32'(eq[0]));
          eq.delete(0);
        end
        mgot++;
      end
      if (mgot == mlen) begin
        exp_done = oh(owner);
        mptr     = (owner + 1) % N;
        owner    = -1;
      end else begin
        chk("grant_held", 32'(grant), 32'(oh(owner)));
      end
    end else begin
      chk("valid_idle", 32'(c_hs), 0);
    end
    chk("burst_done", 32'(burst_done), 32'(exp_done));
    if (c_idle != 0) begin
      w     = pick(c_idle, mptr);
      owner = w;
      mlen  = blen(c_len, w);
      mgot  = 0;
      chk("grant", 32'(grant), 32'(oh(w)));
    end else if (owner < 0) begin
      chk("grant_idle", 32'(grant), 0);
    end
    chk("busy", 32'(busy), 32'(owner >= 0));
  endtask

  // One clock: settle inputs, capture handshakes, edge, FIFO pop, sample at negedge.
  task automatic cycle();
    #1;
    if (rempty) chk("rinc_when_empty", 32'(rinc), 0);
    c_pop  = rinc;
    c_hs   = rd_valid & rd_ready;
    c_data = rd_data;
    c_idle = (model_en && owner < 0) ? req : '0;
    c_len  = req_len;
    @(posedge rclk);
    #1;
    if (c_pop) begin
      if (fq.size() > 0) fq.delete(0);
      pop_cnt++;
    end
    drive_fifo();
    @(negedge rclk);
    if (grant != 0 && prev_grant == 0)
      for (int i = 0; i < N; i++) if (grant[i]) gq.push_back(i);
    prev_grant = grant;
    if (model_en) model_check();
  endtask

  // Run until every requester has finished its burst and withdrawn.
  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while (req != 0 && n < budget) begin
      cycle();
      for (int i = 0; i < N; i++) if (burst_done[i]) req[i] = 1'b0;
      n++;
    end
    if (req != 0) begin
      chk("drain_timeout", 32'(req), 0);
      req = '0;
    end
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n;
    n = 0;
    while (pop_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    if (pop_cnt < target) chk("pop_timeout", 32'(pop_cnt), 32'(target));
  endtask

  initial begin
    int exp_rr[6];
    exp_rr = '{1, 3, 0, 1, 3, 0};

    Rrst_n = 1'b1; req = '0; req_len = '0; rd_ready = '0; prev_grant = '0;
    drive_fifo();
    #1 Rrst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_done", 32'(burst_done), 0);
    chk("rst_rinc", 32'(rinc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(rd_data), 0);
    @(negedge rclk);
    @(negedge rclk);
    Rrst_n   = 1'b1;
    model_en = 1'b1;

    // Single burst of 3 to requester 0.
    push(3); set_len(0, 3); rd_ready = '1; req = 4'b0001; pop_cnt = 0;
    run_drain(40);
    chk("single_pops", 32'(pop_cnt), 3);

    // Round robin over 0,1,3 with length 2; pointer starts at 1 after the burst above.
    push(30); set_len(0, 2); set_len(1, 2); set_len(3, 2);
    gq.delete(); req = 4'b1011;
    for (int n = 0; n < 100 && gq.size() < 6; n++) cycle();
    run_drain(100);
    for (int k = 0; k < 6; k++)
      chk("rr_order", (k < gq.size()) ? 32'(gq[k]) : 32'hffff_ffff, 32'(exp_rr[k]));
    flush();

    // Empty stall then 4 words.
    set_len(1, 4); req = 4'b0010; pop_cnt = 0;
    repeat (6) cycle();
    chk("stall_pops", 32'(pop_cnt), 0);
    chk("stall_grant", 32'(grant), 32'(4'b0010));
    push(4);
    run_drain(40);
    chk("stall_total_pops", 32'(pop_cnt), 4);

    // Abort requester 2 after 2 of 5 pops.
    model_en = 1'b0;
    push(10); set_len(2, 5); req = 4'b0100; pop_cnt = 0;
    wait_pops(2, 20);
    req = '0;
    cycle();
    chk("abort_done", 32'(burst_done), 32'(4'b0100));
    chk("abort_grant", 32'(grant), 0);
    chk("abort_valid", 32'(rd_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (3) cycle();
    chk("abort_pops", 32'(pop_cnt), 2);
    chk("abort_pulse", 32'(burst_done), 0);
    flush(); owner = -1; mptr = 3; model_en = 1'b1;
    push(10); set_len(0, 1); set_len(3, 1); gq.delete(); req = 4'b1001;
    run_drain(40);
    chk("abort_next", (gq.size() > 0) ? 32'(gq[0]) : 32'hffff_ffff, 3);

    // Length field 0 means 16 words.
    push(20); set_len(0, 0); req = 4'b0001; pop_cnt = 0;
    run_drain(100);
    chk("len0_pops", 32'(pop_cnt), 16);

    // Async reset in the middle of a burst (remaining 3).
    model_en = 1'b0;
    flush(); push(10); set_len(2, 5); req = 4'b0100; pop_cnt = 0;
    wait_pops(2, 20);
    #2 Rrst_n = 1'b0;
    #1;
    chk("mrst_grant", 32'(grant), 0);
    chk("mrst_valid", 32'(rd_valid), 0);
    chk("mrst_done", 32'(burst_done), 0);
    chk("mrst_rinc", 32'(rinc), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_data", 32'(rd_data), 0);
    for (int i = 0; i < N; i++) set_len(i, 1);
    req = '1;
    cycle();
    chk("mrst_hold", 32'(grant), 0);
    flush(); owner = -1; mptr = 0; prev_grant = '0; gq.delete();
    Rrst_n = 1'b1; model_en = 1'b1;
    push(8);
    cycle();
    chk("mrst_first", (gq.size() > 0) ? 32'(gq[0]) : 32'hffff_ffff, 0);

    // Randomized traffic with backpressure, stalls and length changes.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (burst_done[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          if (req[i]) set_len(i, int'($urandom_range(0, 15)));
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          set_len(i, int'($urandom_range(0, 15)));
        end else if (req[i] && $urandom_range(0, 7) == 0) begin
          set_len(i, int'($urandom_range(0, 15)));
        end
      end
      rd_ready = N'($urandom) | N'($urandom);
      if (fq.size() < 40 && $urandom_range(0, 2) != 0) push(int'($urandom_range(1, 2)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
